// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   clog2() : ceiling log2, used to size the iteration counter
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= v. Evaluated at elaboration only.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_rca.sv
// N-bit ripple-carry adder.
//   P, Q : addends
//   Cin  : carry in
//   Sum  : N-bit sum
//   Cout : carry out of the MSB
module RCA #(
    parameter int N = 4
) (
    input  logic [N-1:0] P,
    input  logic [N-1:0] Q,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    // carry[gi] is the carry into bit gi; carry[N] is the final carry out.
    logic [N:0] carry;

    assign carry[0] = Cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            assign Sum[gi]     = P[gi] ^ Q[gi] ^ carry[gi];
            assign carry[gi+1] = (P[gi] & Q[gi]) | (carry[gi] & (P[gi] ^ Q[gi]));
        end
    endgenerate

    assign Cout = carry[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN shift-and-add multiplier. One partial-product
// addition per clock through an N-bit ripple-carry adder; N iterations
// per operation, no early exit.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   start   : capture A/B and begin (accepted in IDLE and DONE only)
//   A, B    : unsigned multiplicand / multiplier
//   busy    : high while iterating (state RUN)
//   done    : one-cycle pulse, Product was just updated
//   Product : last completed 2N-bit product, held until next completion
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] Product
);

    localparam int CW = clog2(N + 1);

    state_t         state_reg,   state_next;
    logic [N-1:0]   acc_reg,     acc_next;
    logic [N-1:0]   mreg_reg,    mreg_next;
    logic [N-1:0]   areg_reg,    areg_next;
    logic [CW-1:0]  cnt_reg,     cnt_next;
    logic [2*N-1:0] product_reg, product_next;

    logic [N-1:0]   add_q;
    logic [N-1:0]   add_s;
    logic           add_c;
    logic [2*N-1:0] shifted;

    // Add the multiplicand only when the current multiplier LSB is set.
    assign add_q = mreg_reg[0] ? areg_reg : '0;

    RCA #(.N(N)) u_rca (
        .P    (acc_reg),
        .Q    (add_q),
        .Cin  (1'b0),
        .Sum  (add_s),
        .Cout (add_c)
    );

    // {c, s, mreg} >> 1: the adder carry becomes the new acc MSB, so the
    // upper half can never overflow; the consumed multiplier bit falls off.
    assign shifted = {add_c, add_s, mreg_reg[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            mreg_reg    <= '0;
            areg_reg    <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            mreg_reg    <= mreg_next;
            areg_reg    <= areg_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        mreg_next    = mreg_reg;
        areg_next    = areg_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;

        case (state_reg)
            IDLE, DONE: begin
                // DONE behaves like IDLE for a new request, which is what
                // allows back-to-back operations without an idle gap.
                if (start) begin
                    areg_next  = A;
                    mreg_next  = B;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                {acc_next, mreg_next} = shifted;
                cnt_next              = cnt_reg + CW'(1);
                if (cnt_reg == CW'(N - 1)) begin
                    product_next = shifted;
                    state_next   = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign Product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*N-1:0] Product;

    int checks_total;
    int checks_passed;

    shift_add_multiplier #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Product (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks_total = checks_total + 1;
        if (actual === expected) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at a negedge. Issues a one-cycle start, scrambles A/B while busy,
    // counts busy cycles until done, then checks Product and the done width.
    task automatic do_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [2*N-1:0] expected, input string tag,
                           input bit full);
        int  busy_cycles;
        bit  seen;
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = ~a;
        B = ~b;
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 4 * N + 4; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles = busy_cycles + 1;
            @(negedge clk);
        end
        if (full) begin
            check({tag, " done_seen"}, 64'(seen), 64'd1);
            check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(N));
        end
        check({tag, " product"}, 64'(Product), 64'(expected));
        $display("mult %s: %0d x %0d -> %0d (busy %0d cycles)", tag, a, b, Product, busy_cycles);
        @(negedge clk);
        if (full) check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int done_pulses;
        bit seen;

        checks_total  = 0;
        checks_passed = 0;

        vecs[0] = '{a: 4'd13, b: 4'd11, p: 8'd143};
        vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'd225};
        vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
        vecs[3] = '{a: 4'd9,  b: 4'd0,  p: 8'd0};
        vecs[4] = '{a: 4'd1,  b: 4'd15, p: 8'd15};
        vecs[5] = '{a: 4'd2,  b: 4'd3,  p: 8'd6};
        vecs[6] = '{a: 4'd15, b: 4'd1,  p: 8'd15};
        vecs[7] = '{a: 4'd10, b: 4'd12, p: 8'd120};

        // Reset then idle
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle busy", 64'(busy), 64'd0);
            check("idle done", 64'(done), 64'd0);
            check("idle product", 64'(Product), 64'd0);
        end

        // Basic 13 x 11 and hold afterwards
        do_mult(4'd13, 4'd11, 8'd143, "basic", 1'b1);
        repeat (5) @(negedge clk);
        check("hold product", 64'(Product), 64'd143);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            do_mult(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i), 1'b1);
        end

        // Start ignored while busy
        A = 4'd3;
        B = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 4'd7;
        B = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_pulses = done_pulses + 1;
            @(negedge clk);
        end
        check("ignore done_pulses", 64'(done_pulses), 64'd1);
        check("ignore product", 64'(Product), 64'd15);
        check("ignore idle after", 64'(busy), 64'd0);
        $display("mult ignore: 3 x 5 with restart attempt -> %0d, %0d done pulses", Product, done_pulses);

        // Back-to-back: 2 x 3 then 6 x 7 issued in the done cycle
        A = 4'd2;
        B = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 * N; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("b2b first done", 64'(seen), 64'd1);
        check("b2b first product", 64'(Product), 64'd6);
        $display("mult b2b first: 2 x 3 -> %0d", Product);
        A = 4'd6;
        B = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b no idle gap", 64'(busy), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 4 * N; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("b2b second done", 64'(seen), 64'd1);
        check("b2b second product", 64'(Product), 64'd42);
        $display("mult b2b second: 6 x 7 -> %0d", Product);
        @(negedge clk);

        // Asynchronous reset mid-RUN
        A = 4'd13;
        B = 4'd11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst product", 64'(Product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_pulses = done_pulses + 1;
        end
        check("midrst no done", 64'(done_pulses), 64'd0);
        check("midrst product after", 64'(Product), 64'd0);
        $display("mult midrst: aborted, Product=%0d", Product);

        // Exhaustive 4-bit sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_mult(4'(a), 4'(b), 8'(a * b), $sformatf("ex_%0d_%0d", a, b), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
